// File: rtl/return_stack.sv
// return_stack -- hardware return-address stack for a PC sequencer.
//
// Parameters:
//   DataWidth    width of each stored return address
//   Depth        number of entries (power of two, >= 2)
//   OverflowMode push-when-full policy: 0 = refuse, 1 = wrap over oldest
//
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous active-low reset
//   Push       push DIn this cycle
//   Pop        pop the top entry this cycle
//   DIn        address to push
//   ErrClr     clears the sticky Overflow/Underflow flags
//   DOut       current top of stack (zero when empty)
//   Count      number of valid entries, 0..Depth
//   Empty      Count == 0
//   Full       Count == Depth
//   Overflow   sticky: push attempted while full
//   Underflow  sticky: pop attempted while empty
module return_stack #(
    parameter int unsigned DataWidth    = 16,
    parameter int unsigned Depth        = 8,
    parameter int unsigned OverflowMode = 0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Push,
    input  logic                       Pop,
    input  logic [DataWidth-1:0]       DIn,
    input  logic                       ErrClr,
    output logic [DataWidth-1:0]       DOut,
    output logic [$clog2(Depth):0]     Count,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(Depth);

    logic [DataWidth-1:0] mem [Depth];

    logic [PtrW-1:0] sp;
    logic [PtrW-1:0] sp_nxt;
    logic [PtrW-1:0] top_idx;
    logic [PtrW-1:0] waddr;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_nxt;
    logic            we;
    logic            set_ov;
    logic            set_un;
    logic            ov_q;
    logic            un_q;

    assign Empty   = (cnt == '0);
    assign Full    = (cnt == FullCount);
    assign top_idx = sp - 1'b1;          // wraps modulo Depth
    assign DOut    = Empty ? '0 : mem[top_idx];
    assign Count   = cnt;
    assign Overflow  = ov_q;
    assign Underflow = un_q;

    always_comb begin
        we      = 1'b0;
        waddr   = sp;
        sp_nxt  = sp;
        cnt_nxt = cnt;
        set_ov  = 1'b0;
        set_un  = 1'b0;
        if (Push && Pop) begin
            if (Empty) begin
                // Nothing to pop: behave as a plain push, but flag it.
                we      = 1'b1;
                sp_nxt  = sp + 1'b1;
                cnt_nxt = cnt + 1'b1;
                set_un  = 1'b1;
            end else begin
                // Replace the top in place (tail-call style); depth unchanged.
                we    = 1'b1;
                waddr = top_idx;
            end
        end else if (Push) begin
            if (!Full) begin
                we      = 1'b1;
                sp_nxt  = sp + 1'b1;
                cnt_nxt = cnt + 1'b1;
            end else begin
                set_ov = 1'b1;
                if (OverflowMode == 1) begin
                    // Circular overwrite: the slot at SP holds the oldest entry.
                    we     = 1'b1;
                    sp_nxt = sp + 1'b1;
                end
            end
        end else if (Pop) begin
            if (!Empty) begin
                sp_nxt  = sp - 1'b1;
                cnt_nxt = cnt - 1'b1;
            end else begin
                set_un = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sp   <= '0;
            cnt  <= '0;
            ov_q <= 1'b0;
            un_q <= 1'b0;
        end else begin
            sp   <= sp_nxt;
            cnt  <= cnt_nxt;
            // A setting event wins over a simultaneous clear.
            ov_q <= set_ov | (ov_q & ~ErrClr);
            un_q <= set_un | (un_q & ~ErrClr);
        end
    end

    // Storage is not reset; a write coinciding with reset is suppressed.
    always_ff @(posedge Clk) begin
        if (Reset && we) begin
            mem[waddr] <= DIn;
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack -- directed, table-driven bench for return_stack.
// Two instances (refuse and wrap overflow policies) share all inputs.
module tb_return_stack;

    logic        Clk;
    logic        Reset;
    logic        Push;
    logic        Pop;
    logic [15:0] DIn;
    logic        ErrClr;

    logic [15:0] dout0, dout1;
    logic [3:0]  cnt0, cnt1;
    logic        empty0, empty1, full0, full1, ov0, ov1, un0, un1;

    int errors = 0;
    int checks = 0;

    return_stack #(.DataWidth(16), .Depth(8), .OverflowMode(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Push(Push), .Pop(Pop), .DIn(DIn),
        .ErrClr(ErrClr), .DOut(dout0), .Count(cnt0), .Empty(empty0),
        .Full(full0), .Overflow(ov0), .Underflow(un0)
    );

    return_stack #(.DataWidth(16), .Depth(8), .OverflowMode(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Push(Push), .Pop(Pop), .DIn(DIn),
        .ErrClr(ErrClr), .DOut(dout1), .Count(cnt1), .Empty(empty1),
        .Full(full1), .Overflow(ov1), .Underflow(un1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic        errclr;
        logic [15:0] din;
        logic [15:0] dout;
        logic [3:0]  cnt;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic pu, input logic po, input logic ec,
                                input logic [15:0] din, input logic [15:0] dout,
                                input logic [3:0] cnt, input logic ov, input logic un);
        vec_t v;
        v.push = pu; v.pop = po; v.errclr = ec; v.din = din;
        v.dout = dout; v.cnt = cnt; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic pu, input logic po, input logic ec, input logic [15:0] din);
        Push = pu; Pop = po; ErrClr = ec; DIn = din;
        @(posedge Clk);
        #1;
        Push = 1'b0; Pop = 1'b0; ErrClr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        #2;
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_empty", 32'(empty0), 32'd1);
        check("rst_full",  32'(full0), 32'd0);
        check("rst_dout",  32'(dout0), 32'd0);
        check("rst_flags", {30'd0, ov0, un0}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b1; Push = 1'b0; Pop = 1'b0; ErrClr = 1'b0; DIn = '0;
        #1 Reset = 1'b0;

        // push,pop,errclr,din -> dout,count,ov,un (same for both policies)
        tbl[0]  = mk(1, 0, 0, 16'h0010, 16'h0010, 4'd1, 0, 0);
        tbl[1]  = mk(1, 0, 0, 16'h0020, 16'h0020, 4'd2, 0, 0);
        tbl[2]  = mk(1, 0, 0, 16'h0030, 16'h0030, 4'd3, 0, 0);
        tbl[3]  = mk(0, 1, 0, 16'h0000, 16'h0020, 4'd2, 0, 0);
        tbl[4]  = mk(0, 1, 0, 16'h0000, 16'h0010, 4'd1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 16'h0000, 16'h0000, 4'd0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 16'h0011, 16'h0011, 4'd1, 0, 0);
        tbl[7]  = mk(1, 0, 0, 16'h0022, 16'h0022, 4'd2, 0, 0);
        tbl[8]  = mk(1, 1, 0, 16'h0033, 16'h0033, 4'd2, 0, 0);
        tbl[9]  = mk(0, 1, 0, 16'h0000, 16'h0011, 4'd1, 0, 0);
        tbl[10] = mk(0, 1, 0, 16'h0000, 16'h0000, 4'd0, 0, 0);
        tbl[11] = mk(0, 1, 1, 16'h0000, 16'h0000, 4'd0, 0, 1);
        tbl[12] = mk(0, 0, 1, 16'h0000, 16'h0000, 4'd0, 0, 0);
        tbl[13] = mk(1, 1, 0, 16'h0044, 16'h0044, 4'd1, 0, 1);
        tbl[14] = mk(0, 0, 1, 16'h0000, 16'h0044, 4'd1, 0, 0);
        tbl[15] = mk(0, 1, 0, 16'h0000, 16'h0000, 4'd0, 0, 0);

        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].errclr, tbl[i].din);
            check($sformatf("v%0d_dout", i),  32'(dout0), 32'(tbl[i].dout));
            check($sformatf("v%0d_count", i), 32'(cnt0), 32'(tbl[i].cnt));
            check($sformatf("v%0d_empty", i), 32'(empty0), 32'(tbl[i].cnt == 4'd0));
            check($sformatf("v%0d_full", i),  32'(full0), 32'(tbl[i].cnt == 4'd8));
            check($sformatf("v%0d_ov", i),    32'(ov0), 32'(tbl[i].ov));
            check($sformatf("v%0d_un", i),    32'(un0), 32'(tbl[i].un));
            check($sformatf("v%0d_dout_w", i),  32'(dout1), 32'(tbl[i].dout));
            check($sformatf("v%0d_count_w", i), 32'(cnt1), 32'(tbl[i].cnt));
        end

        // Fill past capacity: refuse vs wrap policy.
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0, 1'b0, 16'(k));
            if (k == 8) begin
                check("fill8_full", 32'(full0), 32'd1);
                check("fill8_ov",   32'(ov0), 32'd0);
            end
        end
        check("ovf_count0", 32'(cnt0), 32'd8);
        check("ovf_full0",  32'(full0), 32'd1);
        check("ovf_dout0",  32'(dout0), 32'h0008);
        check("ovf_flag0",  32'(ov0), 32'd1);
        check("ovf_count1", 32'(cnt1), 32'd8);
        check("ovf_dout1",  32'(dout1), 32'h0009);
        check("ovf_flag1",  32'(ov1), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("pop%0d_dout0", k), 32'(dout0), 32'(8 - k));
            check($sformatf("pop%0d_dout1", k), 32'(dout1), 32'(9 - k));
            step(1'b0, 1'b1, 1'b0, 16'h0000);
        end
        check("drain_empty0", 32'(empty0), 32'd1);
        check("drain_dout1",  32'(dout1), 32'd0);
        check("drain_un1",    32'(un1), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        check("pop9_un1",    32'(un1), 32'd1);
        check("pop9_count1", 32'(cnt1), 32'd0);
        check("pop9_ov1",    32'(ov1), 32'd1);
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        check("clr_flags1", {30'd0, ov1, un1}, 32'd0);

        // Asynchronous reset between edges aborts an in-flight push.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0001);
        step(1'b1, 1'b0, 1'b0, 16'h0002);
        step(1'b1, 1'b0, 1'b0, 16'h0003);
        check("pre_rst_count", 32'(cnt0), 32'd3);
        Push = 1'b1; DIn = 16'h0055;
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(cnt0), 32'd0);
        check("mid_rst_dout",  32'(dout0), 32'd0);
        check("mid_rst_empty", 32'(empty0), 32'd1);
        #2 Reset = 1'b1;
        DIn = 16'h00AA;
        @(posedge Clk);
        #1;
        Push = 1'b0;
        check("post_rst_count", 32'(cnt0), 32'd1);
        check("post_rst_dout",  32'(dout0), 32'h00AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
